instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a fetch PC feeding a 2-entry {instr, pc} queue toward decode.
// Optional macro IFU_FETCH_EXC_EN adds the out_exc flag and alignment/range fetch checks.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef IFU_FETCH_EXC_EN
    ,
    output logic        out_exc
`endif
);

    logic [31:0] r_fpc;
    logic [1:0]  r_count;
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [31:0] r_instr [0:1];
    logic [31:0] r_pc    [0:1];

    logic        w_pop;
    logic        w_room;
    logic        w_push;
    logic [31:0] w_push_instr;
    logic [31:0] w_next_fpc;

    assign imem_addr = r_fpc;
    assign out_valid = (r_count != 2'd0);
    assign w_pop     = out_valid & out_ready;
    // A pop frees a slot in the same cycle, so a full queue still accepts a push.
    assign w_room    = (r_count != 2'd2) | w_pop;

`ifdef IFU_FETCH_EXC_EN
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) << 2;

    logic        r_halt;
    logic        r_exc [0:1];
    logic [32:0] w_offset;
    logic        w_bad;

    // Addresses below RESET_PC wrap to a huge offset and fail the same compare.
    assign w_offset     = {1'b0, r_fpc} - {1'b0, RESET_PC};
    assign w_bad        = (r_fpc[1:0] != 2'b00) || (w_offset >= IMEM_BYTES);
    assign w_push       = !redirect_valid && w_room && !r_halt;
    assign w_push_instr = w_bad ? 32'h0 : imem_rdata;
    assign w_next_fpc   = w_bad ? r_fpc : r_fpc + 32'd4;
    assign out_exc      = out_valid ? r_exc[r_rd_ptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            r_halt <= 1'b0;
        end else if (w_push && w_bad) begin
            r_halt <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_exc[r_wr_ptr] <= w_bad;
        end
    end
`else
    assign w_push       = !redirect_valid && w_room;
    assign w_push_instr = imem_rdata;
    assign w_next_fpc   = r_fpc + 32'd4;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fpc    <= RESET_PC;
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else if (redirect_valid) begin
            r_fpc    <= redirect_pc;
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_fpc    <= w_next_fpc;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wr_ptr] <= w_push_instr;
            r_pc[r_wr_ptr]    <= r_fpc;
        end
    end

    assign out_instr = out_valid ? r_instr[r_rd_ptr] : 32'h0;
    assign out_pc    = out_valid ? r_pc[r_rd_ptr]    : 32'h0;

endmodule
